// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the uart_tx arbiter: byte width and FSM state encodings.
// Imported by the arbiter top and its rotate-priority picker.
package uart_tx_arbiter_pkg;

    localparam int unsigned UART_DW = 8;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD      = 3'd1;
    localparam logic [2:0] S_WR        = 3'd2;
    localparam logic [2:0] S_WAIT_BSY  = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;

endpackage

// File: rtl/uart_tx_rr_pick.sv
// Combinational rotate-priority pick: first set bit of eligible at or after ptr,
// wrapping N-1 -> 0. Works for non-power-of-2 N.
module uart_tx_rr_pick #(
    parameter int unsigned N = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          found
);

    logic [IW:0]   sum;
    logic [IW-1:0] cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        sum    = '0;
        cand   = '0;
        for (int unsigned off = 0; off < N; off++) begin
            sum = {1'b0, ptr} + (IW+1)'(off);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            cand = sum[IW-1:0];
            if (!found && eligible[cand]) begin
                found        = 1'b1;
                idx          = cand;
                onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx among N_REQ byte requesters, with optional
// per-requester message lock so multi-byte messages stay contiguous on the line.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned ACK_TIMEOUT = 64,
    parameter bit          LOCK_EN     = 1'b1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [N_REQ-1:0]         i_req_valid,
    input  logic [UART_DW*N_REQ-1:0] i_req_data,
    input  logic [N_REQ-1:0]         i_req_last,
    output logic [N_REQ-1:0]         o_req_ready,
    output logic [N_REQ-1:0]         o_grant,
    output logic                     o_uart_wr,
    output logic [UART_DW-1:0]       o_uart_data,
    input  logic                     i_uart_bsy,
    output logic                     o_err_timeout,
    output logic                     o_busy
);

    localparam int unsigned IW = $clog2(N_REQ);
    localparam int unsigned CW = $clog2(ACK_TIMEOUT + 1);

    logic [2:0]         state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      win_q, win_d;
    logic               lock_q, lock_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               last_q, last_d;
    logic [UART_DW-1:0] data_q, data_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   ready_q, ready_d;
    logic               wr_q, wr_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;

    logic [N_REQ-1:0]   owner_mask;
    logic [N_REQ-1:0]   eligible;
    logic [N_REQ-1:0]   pick_onehot;
    logic [IW-1:0]      pick_idx;
    logic               pick_found;
    logic [IW-1:0]      ptr_next;
    logic [CW-1:0]      cnt_inc;

    // While locked, win_q still names the owner even if the grant was dropped.
    assign owner_mask = {{(N_REQ-1){1'b0}}, 1'b1} << win_q;
    assign eligible   = lock_q ? (i_req_valid & owner_mask) : i_req_valid;
    assign ptr_next   = (win_q == IW'(N_REQ - 1)) ? '0 : win_q + 1'b1;
    assign cnt_inc    = cnt_q + 1'b1;

    uart_tx_rr_pick #(
        .N (N_REQ)
    ) u_pick (
        .eligible (eligible),
        .ptr      (ptr_q),
        .onehot   (pick_onehot),
        .idx      (pick_idx),
        .found    (pick_found)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        lock_d  = lock_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        data_d  = data_q;
        grant_d = grant_q;
        ready_d = '0;
        wr_d    = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!i_uart_bsy && pick_found) begin
                    win_d   = pick_idx;
                    grant_d = pick_onehot;
                    ready_d = pick_onehot;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (i_req_valid[win_q]) begin
                    data_d  = i_req_data[{win_q, 3'b000} +: UART_DW];
                    last_d  = i_req_last[win_q];
                    wr_d    = 1'b1;
                    state_d = S_WR;
                end else begin
                    grant_d = '0;
                    state_d = S_IDLE;
                end
            end
            S_WR: begin
                cnt_d   = '0;
                state_d = S_WAIT_BSY;
            end
            S_WAIT_BSY: begin
                if (i_uart_bsy) begin
                    state_d = S_WAIT_DONE;
                end else if (cnt_inc == CW'(ACK_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    lock_d  = 1'b0;
                    grant_d = '0;
                    ptr_d   = ptr_next;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_WAIT_DONE: begin
                if (!i_uart_bsy) begin
                    state_d = S_IDLE;
                    if (!LOCK_EN || last_q) begin
                        lock_d  = 1'b0;
                        grant_d = '0;
                        ptr_d   = ptr_next;
                    end else begin
                        lock_d = 1'b1;
                    end
                end
            end
            default: begin
                grant_d = '0;
                lock_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            lock_q  <= 1'b0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            data_q  <= '0;
            grant_q <= '0;
            ready_q <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            lock_q  <= lock_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            ready_q <= ready_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign o_req_ready   = ready_q;
    assign o_grant       = grant_q;
    assign o_uart_wr     = wr_q;
    assign o_uart_data   = data_q;
    assign o_err_timeout = err_q;
    assign o_busy        = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queues and a uart busy stub are
// stepped once per cycle by tick(), all sampling on the falling edge.
module tb_uart_tx_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned AT = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  valid;
    logic [8*N-1:0] data;
    logic [N-1:0]  last;
    logic [N-1:0]  ready;
    logic [N-1:0]  grant;
    logic          uart_wr;
    logic [7:0]    uart_data;
    logic          bsy;
    logic          err;
    logic          busy;

    uart_tx_arbiter #(
        .N_REQ       (N),
        .ACK_TIMEOUT (AT),
        .LOCK_EN     (1'b1)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req_valid   (valid),
        .i_req_data    (data),
        .i_req_last    (last),
        .o_req_ready   (ready),
        .o_grant       (grant),
        .o_uart_wr     (uart_wr),
        .o_uart_data   (uart_data),
        .i_uart_bsy    (bsy),
        .o_err_timeout (err),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] q2[$];
    logic [8:0] q3[$];
    logic [7:0] wr_log[$];
    logic [3:0] gnt_log[$];
    int         ready_cnt [N];
    logic [N-1:0] prev_ready;
    int checks, errors;
    int cyc, wr_cnt, wr_cyc, err_cnt, err_cyc, bcnt, frame, r3_before;
    logic stub_en;

    function automatic logic has(int k);
        case (k)
            0: return q0.size() != 0;
            1: return q1.size() != 0;
            2: return q2.size() != 0;
            default: return q3.size() != 0;
        endcase
    endfunction

    function automatic logic [8:0] head(int k);
        case (k)
            0: return (q0.size() != 0) ? q0[0] : 9'h0;
            1: return (q1.size() != 0) ? q1[0] : 9'h0;
            2: return (q2.size() != 0) ? q2[0] : 9'h0;
            default: return (q3.size() != 0) ? q3[0] : 9'h0;
        endcase
    endfunction

    task automatic refresh();
        logic [8:0] h;
        for (int k = 0; k < 4; k++) begin
            h = head(k);
            valid[k]      = has(k);
            last[k]       = h[8];
            data[8*k +: 8] = h[7:0];
        end
    endtask

    task automatic push(int k, logic l, logic [7:0] d);
        case (k)
            0: q0.push_back({l, d});
            1: q1.push_back({l, d});
            2: q2.push_back({l, d});
            default: q3.push_back({l, d});
        endcase
        refresh();
    endtask

    task automatic pop(int k);
        case (k)
            0: if (q0.size() != 0) void'(q0.pop_front());
            1: if (q1.size() != 0) void'(q1.pop_front());
            2: if (q2.size() != 0) void'(q2.pop_front());
            default: if (q3.size() != 0) void'(q3.pop_front());
        endcase
        refresh();
    endtask

    // One cycle: retire bytes accepted last cycle, log DUT activity, run the busy stub.
    task automatic tick();
        @(negedge clk);
        cyc++;
        for (int k = 0; k < 4; k++) if (prev_ready[k]) pop(k);
        for (int k = 0; k < 4; k++) if (ready[k]) ready_cnt[k]++;
        prev_ready = ready;
        if (uart_wr) begin
            wr_log.push_back(uart_data);
            gnt_log.push_back(grant);
            wr_cyc = cyc;
            wr_cnt++;
        end
        if (err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (!rst_n) begin
            bsy  = 1'b0;
            bcnt = 0;
        end else begin
            if (bcnt > 0) begin
                bcnt--;
                if (bcnt == 0) bsy = 1'b0;
            end
            if (uart_wr && stub_en) begin
                bsy  = 1'b1;
                bcnt = frame;
            end
        end
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_wr(string tag, int n);
        for (int i = 0; i < 400 && wr_cnt < n; i++) tick();
        check(tag, wr_cnt, n);
    endtask

    task automatic wait_idle(string tag);
        for (int i = 0; i < 100 && busy !== 1'b0; i++) tick();
        check(tag, {31'b0, busy}, 32'd0);
    endtask

    task automatic check_outputs_zero(string tag);
        check(tag, {ready, grant, uart_wr, uart_data, err, busy}, 32'd0);
    endtask

    task automatic clear_logs();
        wr_log.delete();
        gnt_log.delete();
        wr_cnt = 0;
    endtask

    task automatic check_log(string tag, int idx, logic [7:0] d, logic [3:0] g);
        check({tag, "_data"}, (wr_log.size() > idx) ? {24'b0, wr_log[idx]} : 32'hdead, {24'b0, d});
        check({tag, "_gnt"}, (gnt_log.size() > idx) ? {28'b0, gnt_log[idx]} : 32'hdead, {28'b0, g});
    endtask

    logic [7:0] exp_d [5];
    logic [3:0] exp_g [5];

    initial begin
        checks = 0; errors = 0; cyc = 0; wr_cnt = 0; err_cnt = 0; bcnt = 0;
        wr_cyc = 0; err_cyc = 0; frame = 10; stub_en = 1'b1;
        prev_ready = '0;
        for (int k = 0; k < 4; k++) ready_cnt[k] = 0;
        rst_n = 1'b0; bsy = 1'b0;
        refresh();
        repeat (3) tick();
        check_outputs_zero("reset_outputs");
        rst_n = 1'b1;
        tick();

        // 1: single byte
        push(0, 1'b1, 8'h55);
        wait_wr("t1_wr", 1);
        wait_idle("t1_idle");
        check_log("t1", 0, 8'h55, 4'b0001);
        check("t1_ready_cnt", ready_cnt[0], 1);
        check("t1_grant_free", {28'b0, grant}, 32'd0);

        // 2: round robin from pointer 0 after reset
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        clear_logs();
        push(0, 1'b1, 8'hA0); push(0, 1'b1, 8'hA0);
        push(1, 1'b1, 8'hA1); push(2, 1'b1, 8'hA2); push(3, 1'b1, 8'hA3);
        wait_wr("t2_wr", 5);
        wait_idle("t2_idle");
        exp_d = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < 5; i++) check_log("t2", i, exp_d[i], exp_g[i]);

        // 3: locked message from req1 ahead of req2
        clear_logs();
        push(1, 1'b0, 8'hB1); push(1, 1'b0, 8'hB2); push(1, 1'b1, 8'hB3);
        push(2, 1'b1, 8'hC2);
        wait_wr("t3_wr1", 1);
        wait_idle("t3_gap_idle");
        check("t3_gap_grant", {28'b0, grant}, 32'b0010);
        wait_wr("t3_wr", 4);
        wait_idle("t3_idle");
        exp_d[0:3] = '{8'hB1, 8'hB2, 8'hB3, 8'hC2};
        exp_g[0:3] = '{4'b0010, 4'b0010, 4'b0010, 4'b0100};
        for (int i = 0; i < 4; i++) check_log("t3", i, exp_d[i], exp_g[i]);

        // 4: lock owner stalls, req3 must wait
        clear_logs();
        push(1, 1'b0, 8'hD1);
        wait_wr("t4_wr1", 1);
        wait_idle("t4_idle1");
        r3_before = ready_cnt[3];
        push(3, 1'b1, 8'hD3);
        repeat (200) tick();
        check("t4_stall_wr", wr_cnt, 1);
        check("t4_stall_grant", {28'b0, grant}, 32'b0010);
        check("t4_stall_ready3", ready_cnt[3], r3_before);
        push(1, 1'b1, 8'hD2);
        wait_wr("t4_wr", 3);
        wait_idle("t4_idle");
        check_log("t4_0", 1, 8'hD2, 4'b0010);
        check_log("t4_1", 2, 8'hD3, 4'b1000);

        // 5: busy never rises -> timeout, lock dropped, next requester served
        clear_logs();
        push(0, 1'b0, 8'hE0);
        wait_wr("t5_wr1", 1);
        wait_idle("t5_idle1");
        stub_en = 1'b0;
        push(0, 1'b0, 8'hE1);
        push(1, 1'b1, 8'hF1);
        wait_wr("t5_wr2", 2);
        for (int i = 0; i < 60 && err_cnt == 0; i++) tick();
        check("t5_err_cnt", err_cnt, 1);
        check("t5_err_delay", err_cyc - wr_cyc, AT);
        stub_en = 1'b1;
        wait_wr("t5_wr", 3);
        wait_idle("t5_idle");
        check("t5_err_pulse", {31'b0, err}, 32'd0);
        check_log("t5_1", 1, 8'hE1, 4'b0001);
        check_log("t5_2", 2, 8'hF1, 4'b0010);
        check("t5_err_total", err_cnt, 1);

        // 6: reset while waiting for the frame to finish
        clear_logs();
        frame = 30;
        push(3, 1'b1, 8'h63);
        wait_wr("t6_wr1", 1);
        repeat (4) tick();
        check("t6_busy_mid", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        repeat (3) tick();
        check_outputs_zero("t6_reset_outputs");
        rst_n = 1'b1;
        frame = 10;
        clear_logs();
        push(2, 1'b1, 8'h72);
        push(1, 1'b1, 8'h71);
        wait_wr("t6_wr_first", 1);
        check_log("t6_first", 0, 8'h71, 4'b0010);
        wait_wr("t6_wr_second", 2);
        wait_idle("t6_idle");
        check_log("t6_second", 1, 8'h72, 4'b0100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
